seg_scan: RTL and testbench
===========================

# seg_scan

Four-digit multiplexed seven-segment display driver: the consumer end of the timer's BCD digit outputs (`minute1`, `minute0`, `second1`, `second0`, `finish`). It sits between the timer and the board's common-anode display, runs on the fast system clock, and snapshots the digits once per frame so the display never tears. It scans the digits with dead-time between them, blanks a leading minute zero, lights the minutes/seconds separator point, and optionally blinks the whole display while `finish` is high.

## Interface
Parameters:
- `SCAN_DIV`, 50000: clock cycles per digit slot; must be ≥ 2 and > `DEAD`.
- `DEAD`, 500: cycles at the start of each slot with all anodes off (anti-ghosting); 0 disables it.
- `BLINK_FRAMES`, 125: frames per blink half-period; must be ≥ 1.

Ports:
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `minute1` input 4: BCD tens of minutes.
- `minute0` input 4: BCD units of minutes.
- `second1` input 4: BCD tens of seconds.
- `second0` input 4: BCD units of seconds.
- `finish` input 1: timer finished flag; drives blink.
- `seg` output 8: active-low segments; `seg[7]`=dp, `seg[6:0]`=g..a.
- `an` output 4: active-low digit enables; `an[0]` is the rightmost digit.

## Operation
- Slot counter `cnt` runs 0..SCAN_DIV-1 and then wraps; digit index `idx` (2 bits) advances on each wrap, 3→0.
- Frame start is `cnt==0 && idx==0`. At frame start the four digits and `finish` are captured into snapshot registers. Only snapshots drive the outputs.
- Slot mapping:
  - idx0 → `second0`
  - idx1 → `second1`
  - idx2 → `minute0`, dp lit
  - idx3 → `minute1`
- Segment codes, active-low with dp off: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. Values 10–15 show dash BF. Lit dp clears bit 7, e.g. '0'+dp = 40.
- Leading-zero blank: in slot 3, when snapshot `minute1==0`, `an=4'b1111` for the whole slot.
- Dead-time: for `cnt < DEAD`, `an=4'b1111`. `seg` still carries the slot's code.
- Otherwise `an` has only bit `idx` low.
- Blink (when compiled in):
  - Frame counter counts completed frames 0..BLINK_FRAMES-1; on wrap, `phase` toggles.
  - While snapshot `finish==1` and `phase==1`, `an=4'b1111`.
  - While snapshot `finish==0`, the frame counter and `phase` are held at 0, so the first blank half-period starts exactly BLINK_FRAMES frames after finish is captured.
- All blanking conditions OR together.

## Timing
- Reset asserted, asynchronously: `an=4'b1111`, `seg=8'hFF`, `cnt=0`, `idx=0`, snapshots 0, frame counter 0, `phase=0`.
- The first rising edge after `rst_n` deasserts is a frame start and captures the inputs.
- `seg`/`an` are registered with 1-cycle latency: values computed from `cnt`/`idx`/snapshot in cycle N appear after edge N.
- Input changes are ignored mid-frame. They become visible at the next frame start, with at most 4·SCAN_DIV cycles of delay plus 1 cycle.
- Reset mid-frame aborts the scan immediately. The frame restarts at idx0 with a fresh capture.
- Input changes on the capture edge itself are taken as sampled at that edge. The inputs come from the slow timer clock and must be stable across at least 2 `clk` cycles.
- Frame length is exactly 4·SCAN_DIV cycles, including blanked slots.

## Configuration
- `SEG_BLINK_EN` defined: the frame counter, `phase`, and `finish` blanking are present as described.
- `SEG_BLINK_EN` not defined:
  - The frame counter and `phase` logic are not built.
  - The `finish` input is ignored.
  - The display is never blink-blanked.
  - All other behaviour is identical.

## Test plan
All scenarios use `SCAN_DIV=8`, `DEAD=2`, `BLINK_FRAMES=2`.

1. Reset release with inputs 1,2,3,4 (m1,m0,s1,s0): after reset `an=F`/`seg=FF`. Slot0 then shows `an=E` `seg=99` from cycle offset 2–7, and the slot2 code is A4 with dp (24).
2. `minute1=0`, others 5: slot 3 keeps `an=F` for all 8 cycles; slots 0–2 show 92 (slot2 shows 12).
3. Change `second0` 3→7 in the middle of slot 1: the display keeps 3 until the next frame start, then shows F8.
4. `second0=4'hC`: slot0 `seg=BF`.
5. `finish=1`, `SEG_BLINK_EN` defined: frames 0–1 are lit, frames 2–3 have all anodes off, frames 4–5 are lit. With `finish=0` the display is never blanked.
6. Assert `rst_n=0` mid-slot 2: `an=F`/`seg=FF` immediately without a clock edge. After release the scan restarts at idx0 with a new capture.

Source files
------------

// File: rtl/seg_scan.sv
// Four-digit multiplexed common-anode seven-segment driver with per-frame snapshot,
// dead-time, leading-zero blank and optional finish blink (define SEG_BLINK_EN).
module seg_scan #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEAD         = 500,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] minute1,
    input  logic [3:0] minute0,
    input  logic [3:0] second1,
    input  logic [3:0] second0,
    input  logic       finish,
    output logic [7:0] seg,
    output logic [3:0] an
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0][3:0]  snap_q, snap_d;
    logic             frame_start, slot_end, frame_end;
    logic [3:0]       digit;
    logic             blink_blank;
    logic             blank;
    logic [7:0]       seg_d;
    logic [3:0]       an_d;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    always_comb begin
        frame_start = (cnt_q == '0) && (idx_q == 2'd0);
        slot_end    = (cnt_q == CntW'(SCAN_DIV - 1));
        frame_end   = slot_end && (idx_q == 2'd3);
        cnt_d       = slot_end ? '0 : cnt_q + 1'b1;
        idx_d       = slot_end ? idx_q + 2'd1 : idx_q;
        // Outputs use the incoming snapshot so the capture cycle already shows the new frame.
        snap_d      = frame_start ? {minute1, minute0, second1, second0} : snap_q;
        digit       = snap_d[idx_q];
        seg_d       = {(idx_q != 2'd2), seg7(digit)};
        blank       = (32'(cnt_q) < DEAD)
                   || ((idx_q == 2'd3) && (snap_d[3] == 4'd0))
                   || blink_blank;
        an_d        = blank ? 4'b1111 : ~(4'b0001 << idx_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            idx_q  <= 2'd0;
            snap_q <= '0;
            seg    <= 8'hFF;
            an     <= 4'b1111;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            seg    <= seg_d;
            an     <= an_d;
        end
    end

`ifdef SEG_BLINK_EN
    localparam int unsigned FcW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic           fin_q, fin_d;
    logic           phase_q, phase_d;
    logic [FcW-1:0] fc_q, fc_d;

    always_comb begin
        fin_d       = frame_start ? finish : fin_q;
        blink_blank = fin_d && phase_q;
        fc_d        = fc_q;
        phase_d     = phase_q;
        // Counter and phase stay cleared until a frame with finish set completes.
        if (!fin_q) begin
            fc_d    = '0;
            phase_d = 1'b0;
        end else if (frame_end) begin
            if (fc_q == FcW'(BLINK_FRAMES - 1)) begin
                fc_d    = '0;
                phase_d = ~phase_q;
            end else begin
                fc_d = fc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fin_q   <= 1'b0;
            phase_q <= 1'b0;
            fc_q    <= '0;
        end else begin
            fin_q   <= fin_d;
            phase_q <= phase_d;
            fc_q    <= fc_d;
        end
    end
`else
    logic unused_finish;
    assign unused_finish = finish;
    assign blink_blank   = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan.sv
// Directed self-checking bench for seg_scan with SCAN_DIV=8, DEAD=2, BLINK_FRAMES=2.
module tb_seg_scan;

    logic       clk;
    logic       rst_n;
    logic [3:0] minute1, minute0, second1, second0;
    logic       finish;
    logic [7:0] seg;
    logic [3:0] an;

    int checks   = 0;
    int failures = 0;

    localparam logic [3:0] AnSlot [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    seg_scan #(
        .SCAN_DIV    (8),
        .DEAD        (2),
        .BLINK_FRAMES(2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .minute1(minute1),
        .minute0(minute0),
        .second1(second1),
        .second0(second0),
        .finish (finish),
        .seg    (seg),
        .an     (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Holds reset, loads inputs, releases on a falling edge; next rising edge is frame start.
    task automatic do_reset(input logic [3:0] m1, input logic [3:0] m0,
                            input logic [3:0] s1, input logic [3:0] s0, input logic fin);
        rst_n   = 1'b0;
        minute1 = m1;
        minute0 = m0;
        second1 = s1;
        second0 = s0;
        finish  = fin;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [7:0]  segs [4];
        logic [11:0] exp;
        int          s, o;
        segs = '{8'h99, 8'hB0, 8'h24, 8'hF9};
        rst_n = 1'b0;
        minute1 = 4'd1; minute0 = 4'd2; second1 = 4'd3; second0 = 4'd4; finish = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({an, seg} !== 12'hFFF) begin
            failures++;
            $display("FAIL reset_state got an=%h seg=%h want an=f seg=ff", an, seg);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            s = k / 8;
            o = k % 8;
            exp = {(o < 2) ? 4'hF : AnSlot[s], segs[s]};
            checks++;
            if ({an, seg} !== exp) begin
                failures++;
                $display("FAIL reset_frame k=%0d got an=%h seg=%h want an=%h seg=%h",
                         k, an, seg, exp[11:8], exp[7:0]);
            end
        end
    endtask

    task automatic test_leading_zero;
        logic [7:0]  segs [4];
        logic [11:0] exp;
        int          s, o;
        segs = '{8'h92, 8'h92, 8'h12, 8'hC0};
        do_reset(4'd0, 4'd5, 4'd5, 4'd5, 1'b0);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            s = k / 8;
            o = k % 8;
            exp = {((o < 2) || (s == 3)) ? 4'hF : AnSlot[s], segs[s]};
            checks++;
            if ({an, seg} !== exp) begin
                failures++;
                $display("FAIL leading_zero k=%0d got an=%h seg=%h want an=%h seg=%h",
                         k, an, seg, exp[11:8], exp[7:0]);
            end
        end
    endtask

    task automatic test_snapshot;
        do_reset(4'd1, 4'd2, 4'd3, 4'd3, 1'b0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 12) begin
                second0 = 4'd7;
                minute1 = 4'd7;
            end
            if (k >= 2 && k < 8) begin
                checks++;
                if ({an, seg} !== {4'hE, 8'hB0}) begin
                    failures++;
                    $display("FAIL snap_old_s0 k=%0d got an=%h seg=%h want an=e seg=b0",
                             k, an, seg);
                end
            end
            if (k >= 26 && k < 32) begin
                checks++;
                if ({an, seg} !== {4'h7, 8'hF9}) begin
                    failures++;
                    $display("FAIL snap_hold_m1 k=%0d got an=%h seg=%h want an=7 seg=f9",
                             k, an, seg);
                end
            end
            if (k >= 32) begin
                checks++;
                if ({an, seg} !== {(k >= 34) ? 4'hE : 4'hF, 8'hF8}) begin
                    failures++;
                    $display("FAIL snap_new_s0 k=%0d got an=%h seg=%h want seg=f8", k, an, seg);
                end
            end
        end
    endtask

    task automatic test_dash;
        do_reset(4'd1, 4'hF, 4'd3, 4'hC, 1'b0);
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (k >= 2 && k < 8) begin
                checks++;
                if ({an, seg} !== {4'hE, 8'hBF}) begin
                    failures++;
                    $display("FAIL dash_s0 k=%0d got an=%h seg=%h want an=e seg=bf", k, an, seg);
                end
            end
            if (k >= 18) begin
                checks++;
                if ({an, seg} !== {4'hB, 8'h3F}) begin
                    failures++;
                    $display("FAIL dash_m0_dp k=%0d got an=%h seg=%h want an=b seg=3f",
                             k, an, seg);
                end
            end
        end
    endtask

    task automatic test_blink;
        logic [3:0] exp_an;
        int         f, s, o;
        logic       blink_on;
`ifdef SEG_BLINK_EN
        blink_on = 1'b1;
`else
        blink_on = 1'b0;
`endif
        for (int pass = 0; pass < 2; pass++) begin
            do_reset(4'd1, 4'd2, 4'd3, 4'd4, (pass == 0));
            for (int k = 0; k < 192; k++) begin
                @(negedge clk);
                f = k / 32;
                s = (k / 8) % 4;
                o = k % 8;
                exp_an = (o < 2) ? 4'hF : AnSlot[s];
                if (blink_on && pass == 0 && (f == 2 || f == 3))
                    exp_an = 4'hF;
                checks++;
                if (an !== exp_an) begin
                    failures++;
                    $display("FAIL blink pass=%0d k=%0d got an=%h want an=%h",
                             pass, k, an, exp_an);
                end
            end
        end
    endtask

    task automatic test_async_reset;
        logic [7:0]  segs [4];
        logic [11:0] exp;
        int          s, o;
        segs = '{8'h80, 8'hF8, 8'h02, 8'h92};
        do_reset(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        repeat (21) @(negedge clk);
        minute1 = 4'd5; minute0 = 4'd6; second1 = 4'd7; second0 = 4'd8;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({an, seg} !== 12'hFFF) begin
            failures++;
            $display("FAIL async_reset got an=%h seg=%h want an=f seg=ff", an, seg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            s = k / 8;
            o = k % 8;
            exp = {(o < 2) ? 4'hF : AnSlot[s], segs[s]};
            checks++;
            if ({an, seg} !== exp) begin
                failures++;
                $display("FAIL restart_frame k=%0d got an=%h seg=%h want an=%h seg=%h",
                         k, an, seg, exp[11:8], exp[7:0]);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        minute1 = '0; minute0 = '0; second1 = '0; second0 = '0;
        finish  = 1'b0;
        test_reset();
        test_leading_zero();
        test_snapshot();
        test_dash();
        test_blink();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
